// File: rtl/clk_en_serial_tx_if.sv
// Parallel-word valid/ready handshake between a word producer and clk_en_serial_tx.
interface clk_en_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              out_ready;

  modport master (output in_data, output in_valid, input out_ready);
  modport slave  (input in_data, input in_valid, output out_ready);
endinterface

// File: rtl/clk_en_serial_tx.sv
// UART-style serial transmitter paced by a single-cycle bit-rate enable strobe,
// fed through a one-entry holding buffer so the next word queues during a frame.
module clk_en_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_clk_en,
  clk_en_serial_tx_if.slave bus,
  output logic              out_txd,
  output logic              out_busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              buf_full_q, buf_full_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              busy_q;
  logic              load;

  assign bus.out_ready = ~buf_full_q;
  assign out_txd       = txd_q;
  assign out_busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    txd_d      = txd_q;
    load       = 1'b0;

    // Accept and load never coincide: accept needs an empty buffer, load a full one.
    if (bus.in_valid && !buf_full_q) begin
      buf_d      = bus.in_data;
      buf_full_d = 1'b1;
    end

    if (in_clk_en) begin
      unique case (state_q)
        IDLE:  load = buf_full_q;
        START: begin
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            stop_cnt_d = 1'b0;
            if (PARITY != 0) begin
              txd_d   = par_q;
              state_d = PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            txd_d = shift_d[0];
          end
        end
        PAR: begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (STOP_BITS == 2 && !stop_cnt_q) stop_cnt_d = 1'b1;
          else if (buf_full_q)               load       = 1'b1;
          else                               state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Parity is captured at load time because the shifter destroys the word.
    if (load) begin
      shift_d    = buf_q;
      par_d      = (PARITY == 2) ? ~^buf_q : ^buf_q;
      buf_full_d = 1'b0;
      txd_d      = 1'b0;
      state_d    = START;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_clk_en_serial_tx.sv
// Four transmitter lanes (no/even/odd parity, two stop bits) share clock, reset and enable;
// each lane's driver queues expected words on accept and a line decoder checks the frames.
`timescale 1ns/1ps
module tb_clk_en_serial_tx;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkEn = 1'b0;
  bit   enTied = 1'b0;
  int   enCnt = 0;
  int   checks = 0;
  int   passes = 0;

  logic [N-1:0] txd, busy, ready, validW;
  item_t stimQ[N][$];
  item_t sbQ[N][$];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Enable strobe: one clock in six, or every clock when tied high.
  initial forever begin
    @(posedge clk);
    #1;
    enCnt = (enCnt == 5) ? 0 : enCnt + 1;
    clkEn = enTied || (enCnt == 5);
  end

  for (genvar g = 0; g < N; g++) begin : lane
    localparam int PAR   = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int STOPS = (g == 3) ? 2 : 1;

    clk_en_serial_tx_if #(.DATA_W(DW)) bus ();
    logic txdW, busyW;
    logic lineNow = 1'b1;

    clk_en_serial_tx #(.DATA_W(DW), .PARITY(PAR), .STOP_BITS(STOPS)) dut (
      .in_clk   (clk),
      .in_rst   (rst),
      .in_clk_en(clkEn),
      .bus      (bus),
      .out_txd  (txdW),
      .out_busy (busyW)
    );

    assign txd[g]    = txdW;
    assign busy[g]   = busyW;
    assign ready[g]  = bus.out_ready;
    assign validW[g] = bus.in_valid;

    // Driver: while the buffer is full, keep valid high with junk data that must be ignored.
    initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      forever begin
        @(negedge clk);
        if (stimQ[g].size() == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = '0;
        end else if (!bus.out_ready || rst) begin
          bus.in_valid = 1'b1;
          bus.in_data  = DW'($urandom);
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = stimQ[g][0].data;
          sbQ[g].push_back(stimQ[g].pop_front());
        end
      end
    end

    initial forever begin
      @(posedge rst);
      sbQ[g].delete();
    end

    // Decoder: sample the line just after every enable edge and rebuild frames.
    initial begin : mon
      int phase, bitIdx, stopCnt;
      logic [DW-1:0] word;
      logic parBit, sawPar, enAt;
      item_t expItem;
      phase = 0; bitIdx = 0; stopCnt = 0; word = '0; parBit = 1'b0; sawPar = 1'b0;
      forever begin
        @(posedge clk);
        enAt = clkEn;
        #2;
        if (rst) begin
          phase   = 0;
          lineNow = 1'b1;
        end else if (enAt) begin
          lineNow = txd[g];
          case (phase)
            0: if (!txd[g]) begin
              phase  = 1;
              bitIdx = 0;
              sawPar = 1'b0;
            end
            1: begin
              word[bitIdx] = txd[g];
              bitIdx++;
              if (bitIdx == DW) begin
                phase   = (PAR != 0) ? 2 : 3;
                stopCnt = 0;
              end
            end
            2: begin
              parBit = txd[g];
              sawPar = 1'b1;
              phase  = 3;
            end
            default: begin
              checkOutput($sformatf("lane%0d stop bit", g), txd[g], 1);
              stopCnt++;
              if (stopCnt == STOPS) begin
                phase = 0;
                if (sbQ[g].size() == 0) begin
                  checkOutput($sformatf("lane%0d frame expected", g), 0, 1);
                end else begin
                  expItem = sbQ[g].pop_front();
                  checkOutput($sformatf("lane%0d data", g), word, expItem.data);
                  if (sawPar) checkOutput($sformatf("lane%0d parity", g), parBit, expItem.par);
                end
              end
            end
          endcase
        end
      end
    end

    // The line may only move on enable edges.
    initial forever begin
      @(negedge clk);
      if (!rst) checkOutput($sformatf("lane%0d line held", g), txd[g], lineNow);
    end
  end

  task automatic applyStimulus(input int laneIdx, input logic [DW-1:0] data, input logic par);
    item_t it;
    it.data = data;
    it.par  = par;
    stimQ[laneIdx].push_back(it);
  endtask

  task automatic waitLevel(input int laneIdx, input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (busy[laneIdx] !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy[laneIdx] !== level) checkOutput({name, " timeout"}, busy[laneIdx], level);
  endtask

  task automatic measureBusy(input int laneIdx, input int budget, output int cycles);
    cycles = 0;
    while (busy[laneIdx] && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic drainAll(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = 1'b1;
      for (int i = 0; i < N; i++)
        if (stimQ[i].size() != 0 || busy[i] || !ready[i] || validW[i]) done = 1'b0;
    end
    if (!done) checkOutput("drain timeout", 0, 1);
  endtask

  initial begin
    logic [9:0] t1Bits;
    int c;
    t1Bits = 10'b1101001010;

    repeat (3) @(posedge clk);
    #3;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("reset lane%0d txd", i), txd[i], 1);
      checkOutput($sformatf("reset lane%0d ready", i), ready[i], 1);
      checkOutput($sformatf("reset lane%0d busy", i), busy[i], 0);
    end
    rst = 1'b0;

    $display("[TB] 0xA5 bit sequence, enable every 6th clock");
    applyStimulus(0, 8'hA5, 1'b0);
    waitLevel(0, 1'b1, 60, "t1 start");
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t1 bit%0d", i), txd[0], t1Bits[i]);
      repeat (6) @(negedge clk);
    end
    checkOutput("t1 idle line", txd[0], 1);
    checkOutput("t1 idle busy", busy[0], 0);

    $display("[TB] parity lanes and back-to-back frames");
    applyStimulus(1, 8'hA5, 1'b0);
    applyStimulus(1, 8'h01, 1'b1);
    applyStimulus(2, 8'hA5, 1'b1);
    applyStimulus(0, 8'h3C, 1'b0);
    applyStimulus(0, 8'hC3, 1'b0);
    waitLevel(0, 1'b1, 60, "t3 start");
    measureBusy(0, 400, c);
    checkOutput("t3 busy cycles", c, 120);
    drainAll(600);

    $display("[TB] enable tied high");
    enTied = 1'b1;
    applyStimulus(3, 8'hFF, 1'b0);
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b0);
    fork
      begin
        int c3;
        waitLevel(3, 1'b1, 20, "t4 start");
        measureBusy(3, 100, c3);
        checkOutput("t4 busy cycles", c3, 11);
      end
      begin
        int c0;
        waitLevel(0, 1'b1, 20, "t6 start");
        measureBusy(0, 200, c0);
        checkOutput("t6 busy cycles", c0, 30);
      end
    join
    drainAll(200);
    enTied = 1'b0;

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, 8'h96, 1'b0);
    applyStimulus(0, 8'h69, 1'b0);
    waitLevel(0, 1'b1, 60, "t5 start");
    repeat (24) @(negedge clk);
    checkOutput("t5 line before reset", txd[0], 0);
    checkOutput("t5 ready before reset", ready[0], 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5 async txd", txd[0], 1);
    checkOutput("t5 async ready", ready[0], 1);
    checkOutput("t5 async busy", busy[0], 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    applyStimulus(0, 8'h5A, 1'b0);
    drainAll(300);

    for (int i = 0; i < N; i++)
      checkOutput($sformatf("lane%0d frames outstanding", i), sbQ[i].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
